// File: rtl/reg_pipe_skid_nch.sv
// reg_pipe_skid_nch: N-channel pipeline register slice with a 2-entry skid buffer.
//
// Handshake: a word moves across a port on a rising CLK edge only when that
// port's valid and ready are both 1 at the edge (fire = valid & ready). A
// producer holds valid and data stable until the word fires, and ready may
// not depend combinationally on valid. Here in_ready comes from a register
// (gated only by ENABLE), so there is no path from out_ready to in_ready.
//
// State is the number of words held (EMPTY/ONE/TWO) and is exported directly
// on occupancy. The main register always holds the head word and drives
// out_data. The skid register catches the one word that can arrive in the
// cycle after downstream stalls, before the registered in_ready drops.
//
// Optional build macro: REG_PIPE_SKID_STATS_EN adds saturating xfer_count and
// stall_count outputs. The datapath is identical with and without it.
module reg_pipe_skid_nch #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 32,
    parameter int STATS_W = 16
) (
    input  logic                     CLK,
    input  logic                     CLEAR,
    input  logic                     ENABLE,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy
`ifdef REG_PIPE_SKID_STATS_EN
    ,
    output logic [STATS_W-1:0]       xfer_count,
    output logic [STATS_W-1:0]       stall_count
`endif
);

    localparam int W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           ready_q;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;

    logic           in_fire;
    logic           out_fire;
    logic           load_main_in;
    logic           load_main_skid;
    logic           load_skid;

    // Port decode: both handshake outputs are frozen low while ENABLE=0, which
    // also guarantees no fire (and hence no register update) in that state.
    assign in_ready  = ENABLE & ready_q;
    assign out_valid = ENABLE & (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register plus the registered ready flag, which looks at the next
    // state so in_ready is already low in the first cycle spent in TWO.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

    // Next-state and register-load decode for the occupancy FSM.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        // Downstream stalled: park the new word behind the head.
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                    2'b11: begin
                        // Head leaves while a new word arrives: replace in place.
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    default: begin
                        state_d = ONE;
                    end
                endcase
            end
            TWO: begin
                // in_ready is low here, so only the drain path exists.
                if (out_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Datapath registers: main takes either the input or the skid word; skid
    // only ever takes the input. All channels move together as one vector.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef REG_PIPE_SKID_STATS_EN
    // Saturating transfer and stall counters; both hold while ENABLE=0
    // because out_valid is forced low then.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (out_fire && (xfer_count != {STATS_W{1'b1}})) begin
                xfer_count <= xfer_count + STATS_W'(1);
            end
            if (out_valid && !out_ready && (stall_count != {STATS_W{1'b1}})) begin
                stall_count <= stall_count + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe_skid_nch.sv
// tb_reg_pipe_skid_nch: directed and random checks of reg_pipe_skid_nch.
// Build with REG_PIPE_SKID_STATS_EN defined to include the counter test.
module tb_reg_pipe_skid_nch;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
`ifdef REG_PIPE_SKID_STATS_EN
    localparam int STATS_W = 2;
`else
    localparam int STATS_W = 16;
`endif
    localparam int W = NUM_CH * DATA_W;

    logic         CLK;
    logic         CLEAR;
    logic         ENABLE;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef REG_PIPE_SKID_STATS_EN
    logic [STATS_W-1:0] xfer_count;
    logic [STATS_W-1:0] stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_word;

    reg_pipe_skid_nch #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .STATS_W(STATS_W)
    ) dut (
        .CLK        (CLK),
        .CLEAR      (CLEAR),
        .ENABLE     (ENABLE),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef REG_PIPE_SKID_STATS_EN
        ,
        .xfer_count (xfer_count),
        .stall_count(stall_count)
`endif
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: sample handshakes mid-cycle; they commit at the next edge.
    always @(negedge CLK) begin
        if (CLEAR) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: out_data=%h but no word expected", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (out_data !== exp_word) begin
                        n_err++;
                        $display("FAIL sb_data: out_data=%h expected %h", out_data, exp_word);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] base);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) w[k*DATA_W +: DATA_W] = DATA_W'(base + 8'(k + 1));
        return w;
    endfunction

    task automatic test_reset();
        CLEAR = 1'b1; ENABLE = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        CLEAR = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [W-1:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = mk(8'(8'h10 * (i + 1)));
            in_valid = 1'b1; in_data = w;
            tick();
            n_cmp++; if (out_data !== w) begin n_err++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, w); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
            n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] a, b, c;
        a = mk(8'hA0); b = mk(8'hB0); c = mk(8'hC0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a; tick();
        in_data = b; tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_full: got %0d expected 2", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
        in_data = c; tick();
        n_cmp++; if (out_data !== a) begin n_err++; $display("FAIL bp_head_stable: got %h expected %h", out_data, a); end
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_hold: got %0d expected 2", occupancy); end
        out_ready = 1'b1; tick();
        n_cmp++; if (out_data !== b) begin n_err++; $display("FAIL bp_second: got %h expected %h", out_data, b); end
        n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ_one: got %0d expected 1", occupancy); end
        tick();
        n_cmp++; if (out_data !== c) begin n_err++; $display("FAIL bp_third: got %h expected %h", out_data, c); end
        in_valid = 1'b0; tick();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d words expected 0", exp_q.size()); end
    endtask

    task automatic test_freeze();
        logic [W-1:0] d, e;
        d = mk(8'hD0); e = mk(8'hE0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = d; tick();
        in_data = e; tick();
        in_valid = 1'b0; ENABLE = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL frz_valid[%0d]: got %b expected 0", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL frz_ready[%0d]: got %b expected 0", i, in_ready); end
            n_cmp++; if (out_data !== d) begin n_err++; $display("FAIL frz_data[%0d]: got %h expected %h", i, out_data, d); end
            n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL frz_occ[%0d]: got %0d expected 2", i, occupancy); end
        end
        ENABLE = 1'b1; tick();
        n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL frz_resume: got %h expected %h", out_data, e); end
        tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL frz_drained: got %0d expected 0", occupancy); end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] g, h, k;
        g = mk(8'h60); h = mk(8'h70); k = mk(8'h80);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = g; tick();
        in_data = h; tick();
        in_valid = 1'b0; CLEAR = 1'b1; tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL mr_occ: got %0d expected 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL mr_data: got %h expected 0", out_data); end
        CLEAR = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = k; tick();
        n_cmp++; if (out_data !== k) begin n_err++; $display("FAIL mr_first_out: got %h expected %h", out_data, k); end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_random();
        int sz;
        for (int i = 0; i < 300; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 2) != 0);
            ENABLE    = ($urandom_range(0, 9) != 0);
            tick();
            sz = exp_q.size();
            n_cmp++; if (occupancy !== 2'(sz)) begin n_err++; $display("FAIL rnd_occ[%0d]: got %0d expected %0d", i, occupancy, sz); end
            n_cmp++; if (out_valid !== (ENABLE && sz != 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, (ENABLE && sz != 0)); end
            n_cmp++; if (in_ready !== (ENABLE && sz != 2)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, (ENABLE && sz != 2)); end
        end
        in_valid = 1'b0; out_ready = 1'b1; ENABLE = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_leftover: got %0d words expected 0", exp_q.size()); end
    endtask

`ifdef REG_PIPE_SKID_STATS_EN
    task automatic test_stats();
        int exp_n;
        CLEAR = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tick();
        CLEAR = 1'b0;
        n_cmp++; if (xfer_count !== 2'd0 || stall_count !== 2'd0) begin n_err++; $display("FAIL st_init: got %0d/%0d expected 0/0", xfer_count, stall_count); end
        in_valid = 1'b1; in_data = mk(8'h90); tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_n = (i > 3) ? 3 : i;
            n_cmp++; if (stall_count !== 2'(exp_n)) begin n_err++; $display("FAIL st_stall[%0d]: got %0d expected %0d", i, stall_count, exp_n); end
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = (i < 5); in_data = mk(8'(8'h90 + 8'(i * 16)));
            tick();
            exp_n = (i > 3) ? 3 : i;
            n_cmp++; if (xfer_count !== 2'(exp_n)) begin n_err++; $display("FAIL st_xfer[%0d]: got %0d expected %0d", i, xfer_count, exp_n); end
        end
        n_cmp++; if (stall_count !== 2'd3) begin n_err++; $display("FAIL st_stall_sat: got %0d expected 3", stall_count); end
        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
        n_cmp++; if (xfer_count !== 2'd0 || stall_count !== 2'd0) begin n_err++; $display("FAIL st_clear: got %0d/%0d expected 0/0", xfer_count, stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_freeze();
        test_mid_reset();
        test_random();
`ifdef REG_PIPE_SKID_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_pipe_skid_nch.md
Name: reg_pipe_skid_nch

Overview:
- Parametrised N-channel pipeline register slice with a valid/ready handshake and a 2-entry skid buffer.
- Next generation of the fixed 3-channel, enable-only pipeline register: channel count and width are generic, and back-pressure is handled without data loss.
- Sits between pixel-processing stages, e.g. RGB channel fetch -> grayscale weighting. Sustains 1 transfer/cycle with a registered in_ready.

Parameters:
- NUM_CH, 3, number of channels carried in parallel.
- DATA_W, 32, bits per channel.
- STATS_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLEAR  input  1  synchronous, active-high reset.
- ENABLE  input  1  global run; 0 freezes the slice.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  slice can accept; registered, then gated by ENABLE.
- in_data  input  NUM_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  NUM_CH*DATA_W  packed channels, same layout as in_data.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Clocking and reset: one clock, CLK. Reset CLEAR is synchronous and active-high.
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register. State is encoded by occupancy: EMPTY=0, ONE=1, TWO=2.
- Output decode:
  - in_ready = ENABLE & (state != TWO), from a registered flag.
  - out_valid = ENABLE & (state != EMPTY).
  - in_ready has no combinational path from out_ready.
- Reset (CLEAR=1 at a rising edge): state EMPTY, main=0, skid=0. After reset: out_valid=0, in_ready=ENABLE, occupancy=0, out_data=0.
- CLEAR has priority over every other event. A CLEAR mid-operation discards all held words. No partial output is produced.
- Transitions, ENABLE=1:
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire & !out_fire -> TWO, skid<=in_data.
  - ONE: in_fire & out_fire -> ONE, main<=in_data.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither -> hold.
  - TWO: out_fire -> ONE, main<=skid. No in_fire is possible in TWO.
- ENABLE=0: no fires can occur, all registers hold. Re-asserting ENABLE resumes from the held state.
- Latency: a word accepted in cycle t is presented on out_data with out_valid in cycle t+1 if the slice was EMPTY, or on the cycle after it becomes head otherwise.
- Ordering and integrity:
  - Strict FIFO order; no duplication or loss.
  - Channels travel together and are never reordered across or within words.
  - Data is not modified.
- Throughput: continuous streaming with out_ready=1 gives 1 word/cycle; occupancy stays at 1.
- out_data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: REG_PIPE_SKID_STATS_EN.
- Defined: adds two outputs.
  - xfer_count (STATS_W) increments on each out_fire.
  - stall_count (STATS_W) increments each cycle with out_valid & !out_ready.
  - Both saturate at all-ones, reset to 0 on CLEAR, and hold while ENABLE=0.
- Undefined: the ports and counters do not exist. Datapath behaviour is identical in both builds.

Test Plan:
- Reset: CLEAR=1 for 2 cycles, ENABLE=1 -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
- Streaming: NUM_CH=3, DATA_W=32, out_ready=1; push words {0x11,0x12,0x13}, {0x21,0x22,0x23}, {0x31,0x32,0x33} on consecutive cycles -> each appears 1 cycle later in order; in_ready stays 1; occupancy=1.
- Back-pressure: out_ready=0, push A, B -> occupancy=2, in_ready=0 next cycle; source holds C. Set out_ready=1 -> A, B, C out in order with no loss.
- Freeze: ENABLE=0 at occupancy=2 -> out_valid=0, in_ready=0, out_data unchanged for 5 cycles. Set ENABLE=1 -> drains normally.
- Mid-operation reset: CLEAR=1 at occupancy=2 -> next cycle occupancy=0, out_valid=0, out_data=0; the next pushed word is the first word out.
- Stats build: STATS_W=2, 5 transfers and 4 stall cycles -> xfer_count=3, stall_count=3 (saturated); CLEAR -> both 0.
